muldiv_unit: RTL and testbench

Parametrised sequential multiply/divide unit with architectural HI/LO registers, serving MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO. It sits beside the execute-stage ALU and replaces single-cycle combinational `*`, `/` and `%` with an iterative one-bit-per-cycle engine. It stalls the pipeline through a busy/stall interlock and holds HI/LO across reset-free operation. Operands arrive already resolved through the MX/WX bypass muxes.

---
 rtl/muldiv_unit_if.sv | 29 ++
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_muldiv_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and muldiv_unit.
// The EX side drives the master modport; the unit takes the slave modport.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             rd_req;
  logic             rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             op_ready;
  logic             stall;
  logic             done;
  logic             div_by_zero;

  modport master (
    output op_valid, op, op_a, op_b, flush, rd_req, rd_sel,
    input  rd_data, busy, op_ready, stall, done, div_by_zero
  );

  modport slave (
    input  op_valid, op, op_a, op_b, flush, rd_req, rd_sel,
    output rd_data, busy, op_ready, stall, done, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU engine with HI/LO; divide built only with MULDIV_DIV_EN.
// Mul/div take WIDTH+1 busy cycles (HI/LO valid after); moves take effect next cycle; stall while busy.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic         clock,
  input  logic         reset_n,
  muldiv_unit_if.slave bus
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   hi, lo;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic               neg_res;

  logic               accept, start, signed_op, a_neg, b_neg, last_step;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_next, acc_step, prod_fix;
  logic [WIDTH-1:0]   hi_fix, lo_fix;

  assign accept    = bus.op_valid & (state == IDLE) & ~bus.flush;
  assign signed_op = ~bus.op[0];
  assign a_neg     = signed_op & bus.op_a[WIDTH-1];
  assign b_neg     = signed_op & bus.op_b[WIDTH-1];
  assign a_mag     = a_neg ? -bus.op_a : bus.op_a;
  assign b_mag     = b_neg ? -bus.op_b : bus.op_b;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  // Shift-add: multiplier sits in the low half and drains out as the product fills in.
  assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : '0)};
  assign mul_next = {add_sum, acc[WIDTH-1:1]};
  assign prod_fix = neg_res ? -acc : acc;

`ifdef MULDIV_DIV_EN
  logic               is_div, neg_rem, dz;
  logic [WIDTH-1:0]   a_raw;
  logic               is_div_op;
  logic [WIDTH:0]     rem_shift, rem_diff;
  logic [2*WIDTH-1:0] div_next;

  assign is_div_op = (bus.op == 3'b010) | (bus.op == 3'b011);
  assign start     = accept & ((bus.op == OP_MULT) | (bus.op == OP_MULTU) | is_div_op);

  // Restoring divide: remainder in the high half, dividend shifts out / quotient shifts in low.
  assign rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, mcand};
  assign div_next  = rem_diff[WIDTH] ? {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {rem_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
  assign acc_step  = is_div ? div_next : mul_next;

  always_comb begin
    {hi_fix, lo_fix} = prod_fix;
    if (is_div) begin
      if (dz) begin
        lo_fix = '1;
        hi_fix = a_raw;
      end else begin
        lo_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        hi_fix = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      is_div  <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
      a_raw   <= '0;
    end else if (start) begin
      is_div  <= is_div_op;
      neg_rem <= a_neg;
      dz      <= is_div_op & (bus.op_b == '0);
      a_raw   <= bus.op_a;
    end
  end
`else
  assign start    = accept & ((bus.op == OP_MULT) | (bus.op == OP_MULTU));
  assign acc_step = mul_next;
  assign {hi_fix, lo_fix} = prod_fix;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      acc     <= '0;
      mcand   <= '0;
      neg_res <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        cnt     <= '0;
        acc     <= {{WIDTH{1'b0}}, a_mag};
        mcand   <= b_mag;
        neg_res <= a_neg ^ b_neg;
      end else if (state == CALC) begin
        cnt <= cnt + CNT_W'(1);
        acc <= acc_step;
      end
      if (accept && bus.op == OP_MTHI) hi <= bus.op_a;
      if (accept && bus.op == OP_MTLO) lo <= bus.op_a;
      if (state == FIX && !bus.flush) begin
        hi <= hi_fix;
        lo <= lo_fix;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    bus.busy        = (state != IDLE);
    bus.op_ready    = (state == IDLE);
    bus.stall       = (state != IDLE) & (bus.op_valid | bus.rd_req);
    bus.done        = (state == FIX) & ~bus.flush;
    bus.div_by_zero = 1'b0;
    bus.rd_data     = bus.rd_sel ? hi : lo;
`ifdef MULDIV_DIV_EN
    bus.div_by_zero = (state == FIX) & ~bus.flush & dz;
`endif
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_step) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: cycle-level reference model plus hand-computed HI/LO literals.
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  muldiv_unit_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference result from plain wide arithmetic: {HI, LO}.
  function automatic logic [63:0] model_res(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [31:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    q = '0;
    r = '0;
    case (o)
      3'b000: return 64'(sa * sb);
      3'b001: return ua * ub;
      3'b010: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {r, q};
      end
      3'b011: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = 32'(ua / ub);
        r = 32'(ua % ub);
        return {r, q};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Model: m_left counts the busy cycles still to come; the result lands as it reaches zero.
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] p_res = '0;
  logic        p_dz = 1'b0;

  always @(posedge clock) begin
    if (!reset_n) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (bus.flush) begin
      m_left <= 0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= p_res[63:32];
        m_lo <= p_res[31:0];
      end
    end else if (bus.op_valid) begin
      case (bus.op)
        3'b100: m_hi <= bus.op_a;
        3'b101: m_lo <= bus.op_a;
        3'b000, 3'b001: begin
          p_res  <= model_res(bus.op, bus.op_a, bus.op_b);
          p_dz   <= 1'b0;
          m_left <= W + 1;
        end
        3'b010, 3'b011: if (DIV_EN) begin
          p_res  <= model_res(bus.op, bus.op_a, bus.op_b);
          p_dz   <= (bus.op_b == 0);
          m_left <= W + 1;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("busy", bus.busy, m_left != 0);
      check("op_ready", bus.op_ready, m_left == 0);
      check("stall", bus.stall, (m_left != 0) && (bus.op_valid || bus.rd_req));
      check("done", bus.done, (m_left == 1) && !bus.flush);
      check("div_by_zero", bus.div_by_zero, (m_left == 1) && !bus.flush && p_dz);
      check("rd_data", bus.rd_data, bus.rd_sel ? m_hi : m_lo);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic sel, output logic [31:0] v);
    bus.rd_sel = sel;
    @(negedge clock);
    v = bus.rd_data;
    tick();
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = 1'b1;
    bus.op = o;
    bus.op_a = a;
    bus.op_b = b;
    tick();
    bus.op_valid = 1'b0;
  endtask

  // Issue, then observe cycles N+1..N+36 (k = cycle offset from the accept edge).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int nb, output int dc, output int zc, output int sc,
                        output logic [31:0] d34, output logic s34);
    nb = 0; dc = 0; zc = 0; sc = 0; d34 = '0; s34 = 1'b1;
    issue(o, a, b);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clock);
      if (bus.busy) nb++;
      if (bus.done) dc = k;
      if (bus.div_by_zero) zc = k;
      if (bus.stall) sc++;
      if (k == 34) begin
        d34 = bus.rd_data;
        s34 = bus.stall;
      end
      tick();
    end
  endtask

  task automatic expect_regs(input string tag, input logic [31:0] eh, input logic [31:0] el);
    logic [31:0] v;
    rd(1'b1, v);
    check({tag, "_hi"}, v, eh);
    rd(1'b0, v);
    check({tag, "_lo"}, v, el);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nb, dc, zc, sc, cnt_done;
    logic [31:0] d34, v, kh, kl;
    logic s34;
    bus.op_valid = 1'b0; bus.op = '0; bus.op_a = '0; bus.op_b = '0;
    bus.flush = 1'b0; bus.rd_req = 1'b0; bus.rd_sel = 1'b0;
    reset_n = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    reset_n = 1'b1;
    expect_regs("reset", 32'h0, 32'h0);

    run_op(3'b000, 32'hFFFFFFFD, 32'd7, nb, dc, zc, sc, d34, s34);
    check("mult_busy_cycles", nb, 33);
    check("mult_done_cycle", dc, 33);
    expect_regs("mult", 32'hFFFFFFFF, 32'hFFFFFFEB);

    bus.rd_req = 1'b1;
    bus.rd_sel = 1'b1;
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, nb, dc, zc, sc, d34, s34);
    bus.rd_req = 1'b0;
    check("multu_stall_cycles", sc, 33);
    check("multu_n34_data", d34, 32'hFFFFFFFE);
    check("multu_n34_stall", s34, 1'b0);
    expect_regs("multu", 32'hFFFFFFFE, 32'h00000001);

    kh = DIV_EN ? 32'h5 : 32'hFFFFFFFE;
    kl = DIV_EN ? 32'hFFFFFFFF : 32'h00000001;
    run_op(3'b011, 32'd100, 32'd7, nb, dc, zc, sc, d34, s34);
    check("divu_busy_cycles", nb, DIV_EN ? 33 : 0);
    expect_regs("divu", DIV_EN ? 32'd2 : 32'hFFFFFFFE, DIV_EN ? 32'd14 : 32'h1);
    run_op(3'b010, 32'hFFFFFFF9, 32'd2, nb, dc, zc, sc, d34, s34);
    expect_regs("div_neg", DIV_EN ? 32'hFFFFFFFF : 32'hFFFFFFFE,
                DIV_EN ? 32'hFFFFFFFD : 32'h1);
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, nb, dc, zc, sc, d34, s34);
    check("div_ovf_flag", zc, 0);
    expect_regs("div_ovf", DIV_EN ? 32'h0 : 32'hFFFFFFFE, DIV_EN ? 32'h80000000 : 32'h1);
    run_op(3'b010, 32'd5, 32'd0, nb, dc, zc, sc, d34, s34);
    check("dz_done_cycle", dc, DIV_EN ? 33 : 0);
    check("dz_flag_cycle", zc, DIV_EN ? 33 : 0);
    expect_regs("dz", kh, kl);

    // Reserved code: no busy, no register change.
    issue(3'b110, 32'h11111111, 32'h22222222);
    @(negedge clock);
    check("reserved_busy", bus.busy, 1'b0);
    tick();
    expect_regs("reserved", kh, kl);

    // Flush in the same cycle as a request blocks acceptance.
    bus.flush = 1'b1;
    issue(3'b000, 32'd3, 32'd4);
    bus.flush = 1'b0;
    @(negedge clock);
    check("flush_accept_busy", bus.busy, 1'b0);
    tick();

    // A move requested while busy must be ignored.
    issue(3'b000, 32'd3, 32'd4);
    bus.op_valid = 1'b1; bus.op = 3'b100; bus.op_a = 32'hDEAD;
    repeat (5) tick();
    bus.op_valid = 1'b0;
    repeat (32) tick();
    expect_regs("mult_small", 32'h0, 32'd12);

    issue(3'b101, 32'h1234, 32'h0);
    rd(1'b0, v);
    check("mtlo_next_cycle", v, 32'h1234);
    issue(3'b100, 32'h55, 32'h0);
    rd(1'b1, v);
    check("mthi_next_cycle", v, 32'h55);

    issue(3'b000, 32'd3, 32'd4);
    repeat (10) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    @(negedge clock);
    check("flush_idle", bus.busy, 1'b0);
    cnt_done = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      @(negedge clock);
      if (bus.done) cnt_done++;
    end
    tick();
    check("flush_no_done", cnt_done, 0);
    expect_regs("flush", 32'h55, 32'h1234);

    issue(3'b000, 32'd3, 32'd4);
    repeat (10) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clock);
    check("reset_mid_busy", bus.busy, 1'b0);
    tick();
    expect_regs("reset_mid", 32'h0, 32'h0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
